// File: rtl/pixel_fb_writer_pkg.sv
// Shared graphics definitions: framebuffer defaults, counter width and the
// writer FSM state type.
package pixel_fb_writer_pkg;
    localparam int FB_W_DEF    = 64;
    localparam int FB_H_DEF    = 48;
    localparam int ADDR_W_DEF  = 12;
    localparam int COLOR_W_DEF = 8;
    localparam int CNT_W       = 16;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} fb_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/pixel_fb_writer_fifo.sv
// Show-ahead write FIFO; pointers carry one extra wrap bit to tell full from empty.
module pix_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr, rd_ptr;
    logic [DW-1:0] mem [DEPTH];
    logic          do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/pixel_fb_writer.sv
// Pixel stream to framebuffer writer: clips, drops repeated coordinates,
// queues writes and signals completion of each line.
module pixel_fb_writer
    import pixel_fb_writer_pkg::*;
#(
    parameter int FB_W    = FB_W_DEF,
    parameter int FB_H    = FB_H_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int COLOR_W = COLOR_W_DEF,
    parameter int DEPTH   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pix_valid,
    output logic                pix_ready,
    input  logic signed [31:0]  pix_x,
    input  logic signed [31:0]  pix_y,
    input  logic [COLOR_W-1:0]  pix_color,
    input  logic                line_done,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [COLOR_W-1:0]  mem_wdata,
    input  logic                mem_ready,
    output logic                done,
    output logic [CNT_W-1:0]    wr_cnt,
    output logic [CNT_W-1:0]    clip_cnt,
    output logic [CNT_W-1:0]    dup_cnt
);
    localparam int DW = ADDR_W + COLOR_W;

    fb_state_t          state, state_nx;
    logic               ld_q, ld_rise;
    logic               last_vld;
    logic signed [31:0] last_x, last_y;
    logic               accept, clip, dup, push, pop, full, empty;
    logic [ADDR_W-1:0]  push_addr;
    logic [DW-1:0]      head;

    assign ld_rise   = line_done && !ld_q;
    assign pix_ready = (state == S_IDLE || state == S_RUN) && !full;
    assign accept    = pix_valid && pix_ready;
    assign clip      = (pix_x < 0) || (pix_x >= FB_W) || (pix_y < 0) || (pix_y >= FB_H);
    assign dup       = last_vld && (pix_x == last_x) && (pix_y == last_y);
    assign push      = accept && !clip && !dup;
    assign push_addr = ADDR_W'(pix_y * FB_W + pix_x);

    assign mem_we    = !empty;
    assign pop       = mem_we && mem_ready;
    assign {mem_addr, mem_wdata} = mem_we ? head : '0;
    assign done      = (state == S_DONE);

    pix_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({push_addr, pix_color}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_nx = state;
        case (state)
            // A rise before any pixel closes an empty line straight away.
            S_IDLE:  if (ld_rise) state_nx = S_DRAIN;
                     else if (accept) state_nx = S_RUN;
            S_RUN:   if (ld_rise) state_nx = S_DRAIN;
            S_DRAIN: if (empty) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ld_q     <= 1'b0;
            last_vld <= 1'b0;
            last_x   <= '0;
            last_y   <= '0;
            wr_cnt   <= '0;
            clip_cnt <= '0;
            dup_cnt  <= '0;
        end else begin
            state <= state_nx;
            ld_q  <= line_done;
            if (push) begin
                last_vld <= 1'b1;
                last_x   <= pix_x;
                last_y   <= pix_y;
            end else if (state == S_DONE) begin
                last_vld <= 1'b0;
            end
            if (pop)                     wr_cnt   <= sat_inc(wr_cnt);
            if (accept && clip)          clip_cnt <= sat_inc(clip_cnt);
            if (accept && !clip && dup)  dup_cnt  <= sat_inc(dup_cnt);
        end
    end
endmodule

// File: tb/tb_pixel_fb_writer.sv
// Scoreboard bench for pixel_fb_writer: expected writes are queued at issue
// time and matched by a monitor sampling on the falling edge.
module tb_pixel_fb_writer;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               pix_valid = 1'b0, pix_ready;
    logic signed [31:0] pix_x = 0, pix_y = 0;
    logic [7:0]         pix_color = 8'h00;
    logic               line_done = 1'b0;
    logic               mem_we, mem_ready = 1'b1, done;
    logic [11:0]        mem_addr;
    logic [7:0]         mem_wdata;
    logic [15:0]        wr_cnt, clip_cnt, dup_cnt;

    typedef struct packed { logic [11:0] addr; logic [7:0] color; } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;
    int  tests = 0, fails = 0, writes = 0, dones = 0;

    always #5 clk = ~clk;

    pixel_fb_writer dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .line_done(line_done),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .done(done), .wr_cnt(wr_cnt), .clip_cnt(clip_cnt), .dup_cnt(dup_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && mem_we && mem_ready) begin
            writes++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", int'(mem_addr), -1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("write_addr", int'(mem_addr), int'(mon_e.addr));
                chk("write_color", int'(mem_wdata), int'(mon_e.color));
            end
        end
        if (rst_n && done) dones++;
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; pix_valid = 1'b0; line_done = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; writes = 0; dones = 0;
    endtask

    // Offer one pixel and hold it until accepted; wr_exp queues the write it should cause.
    task automatic send(input int x, input int y, input logic [7:0] c, input bit wr_exp, input int a);
        bit ok = 0;
        pix_x = x; pix_y = y; pix_color = c; pix_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (pix_ready) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        if (ok && wr_exp) exp_q.push_back('{addr: 12'(a), color: c});
        @(posedge clk); #1;
        pix_valid = 1'b0;
    endtask

    task automatic end_line();
        bit seen = 0;
        @(posedge clk); #1;
        line_done = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        chk("done_seen", int'(seen), 1);
        line_done = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        do_reset();
        // reset state
        @(negedge clk);
        chk("rst_pix_ready", pix_ready, 1);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_wr_cnt", wr_cnt, 0);
        chk("rst_clip_cnt", clip_cnt, 0);

        // line scenario, including push-to-write latency
        do_reset();
        pix_x = 1; pix_y = 2; pix_color = 8'h11; pix_valid = 1'b1;
        @(negedge clk);
        chk("lat_ready_first_edge", pix_ready, 1);
        chk("lat_no_bypass", mem_we, 0);
        exp_q.push_back('{addr: 12'd129, color: 8'h11});
        @(posedge clk); #1;
        pix_valid = 1'b0;
        chk("lat_mem_we_after_push", mem_we, 1);
        chk("lat_head_addr", mem_addr, 129);
        send(2, 2, 8'h22, 1, 130);
        send(3, 3, 8'h33, 1, 195);
        end_line();
        chk("line_wr_cnt", wr_cnt, 3);
        chk("line_done_pulses", dones, 1);
        chk("line_queue_empty", exp_q.size(), 0);

        // clip scenario
        do_reset();
        send(-1, 0, 8'h01, 0, 0);
        send(64, 5, 8'h02, 0, 0);
        send(3, 48, 8'h03, 0, 0);
        send(63, 47, 8'h04, 1, 3071);
        end_line();
        chk("clip_cnt", clip_cnt, 3);
        chk("clip_wr_cnt", wr_cnt, 1);
        chk("clip_queue_empty", exp_q.size(), 0);

        // duplicate scenario: one pixel held valid for five edges
        do_reset();
        pix_x = 20; pix_y = 10; pix_color = 8'h5A; pix_valid = 1'b1;
        exp_q.push_back('{addr: 12'd660, color: 8'h5A});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("dup_ready", pix_ready, 1);
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        end_line();
        chk("dup_cnt", dup_cnt, 4);
        chk("dup_wr_cnt", wr_cnt, 1);
        chk("dup_queue_empty", exp_q.size(), 0);

        // backpressure scenario
        do_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(i, 1, 8'(8'h40 + i), 1, 64 + i);
        pix_x = 4; pix_y = 1; pix_color = 8'h44; pix_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready_low", pix_ready, 0);
            chk("bp_addr_stable", mem_addr, 64);
            chk("bp_mem_we", mem_we, 1);
        end
        @(posedge clk); #1;
        mem_ready = 1'b1;
        send(4, 1, 8'h44, 1, 68);
        send(5, 1, 8'h45, 1, 69);
        end_line();
        chk("bp_wr_cnt", wr_cnt, 6);
        chk("bp_queue_empty", exp_q.size(), 0);

        // reset with entries queued
        do_reset();
        mem_ready = 1'b0;
        send(-5, 0, 8'h09, 0, 0);
        for (int i = 0; i < 3; i++) send(10 + i, 0, 8'(8'h70 + i), 1, 10 + i);
        chk("rst_mid_mem_we_before", mem_we, 1);
        chk("rst_mid_clip_before", clip_cnt, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_we", mem_we, 0);
        chk("rst_mid_clip_cnt", clip_cnt, 0);
        chk("rst_mid_mem_addr", mem_addr, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; writes = 0;
        mem_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_mid_no_writes", writes, 0);
        chk("rst_mid_wr_cnt", wr_cnt, 0);

        // empty-line done timing
        do_reset();
        @(posedge clk); #1;
        line_done = 1'b1;
        @(negedge clk); chk("empty_done_e0", done, 0);
        @(negedge clk); chk("empty_done_e1", done, 0);
        @(negedge clk); chk("empty_done_e2", done, 1);
        @(negedge clk); chk("empty_done_e3", done, 0);
        line_done = 1'b0;
        chk("empty_wr_cnt", wr_cnt, 0);
        chk("empty_done_pulses", dones, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
